tdm_demux_4ch: RTL and testbench

- Receive-side counterpart of the team's 4-to-1 multiplexer: rebuilds four parallel channels from one time-division-multiplexed stream.
- Each frame is four consecutive valid beats in slot order 0,1,2,3. Slot 0 is marked by in_sof.
- The block tracks the slot with a 2-bit counter, stages samples, and presents the whole frame in parallel with a one-cycle valid pulse.
- It detects loss of frame alignment and resynchronises on its own.

---
 rtl/tdm_demux_4ch.sv | 145 ++++++++++++++
 tb/tb_tdm_demux_4ch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// ============================================================================
// Module  : tdm_demux_4ch
// Brief   : Rebuilds four parallel channels from a 4-slot TDM stream with
//           SOF-based frame alignment and automatic resynchronisation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux_4ch #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] stage0_q, stage0_d;
    logic [WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0] stage2_q, stage2_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            stage0_q    <= '0;
            stage1_q    <= '0;
            stage2_q    <= '0;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            stage0_q    <= stage0_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out3_q      <= out3_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        stage0_d    = stage0_q;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out3_d      = out3_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        stage0_d = in_data;
                        slot_d   = 2'd1;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (in_sof) begin
                            stage0_d = in_data;
                            slot_d   = 2'd1;
                        end else begin
                            sync_err_d = 1'b1;
                            slot_d     = 2'd0;
                            state_d    = HUNT;
                        end
                    end else if (in_sof) begin
                        // Early SOF: the new beat starts a fresh frame; stale
                        // stage1/stage2 contents are overwritten before use.
                        sync_err_d = 1'b1;
                        stage0_d   = in_data;
                        slot_d     = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        out0_d      = stage0_q;
                        out1_d      = stage1_q;
                        out2_d      = stage2_q;
                        out3_d      = in_data;
                        out_valid_d = 1'b1;
                        slot_d      = 2'd0;
                    end else begin
                        if (slot_q == 2'd1) begin
                            stage1_d = in_data;
                        end else begin
                            stage2_d = in_data;
                        end
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out3      = out3_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;
    assign locked    = (state_q == LOCKED);
    assign sync_err  = sync_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
// ============================================================================
// Module  : tb_tdm_demux_4ch
// Brief   : Scoreboard bench for tdm_demux_4ch (WIDTH=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_4ch;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             out_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             sync_err;

    int checks;
    int errors;
    int ov_cnt;
    int err_cnt;
    logic [4*WIDTH-1:0] exp_q[$];

    tdm_demux_4ch #(.WIDTH(WIDTH)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out_valid(out_valid),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back({a, b, c, d});
    endtask

    // Each beat first checks the state left behind by earlier beats, then drives.
    task automatic beat(input logic [7:0] d, input logic s, input logic [1:0] es,
                        input logic ee, input logic el);
        @(negedge clk);
        check("slot", {30'd0, slot}, {30'd0, es});
        check("sync_err", {31'd0, sync_err}, {31'd0, ee});
        check("locked", {31'd0, locked}, {31'd0, el});
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_data  = 8'hEE;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", {out0, out1, out2, out3}, 32'd0);
        check("rst_flags", {28'd0, out_valid, sync_err, locked, 1'b0},
              32'd0);
        check("rst_slot", {30'd0, slot}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Scoreboard consumer: pops one expected frame per out_valid pulse.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            ov_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_ov", 32'd1, 32'd0);
            end else begin
                check("frame", {out0, out1, out2, out3}, exp_q.pop_front());
            end
        end
        if (rst_n && sync_err) begin
            err_cnt++;
        end
        if (out_valid && sync_err) begin
            check("ov_err_excl", 32'd1, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        ov_cnt   = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        do_reset();

        // Aligned frame
        push_frame(8'hA0, 8'hB1, 8'hC2, 8'hD3);
        beat(8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
        beat(8'hB1, 1'b0, 2'd1, 1'b0, 1'b1);
        beat(8'hC2, 1'b0, 2'd2, 1'b0, 1'b1);
        beat(8'hD3, 1'b0, 2'd3, 1'b0, 1'b1);
        idle(2);
        check("t1_slot_wrap", {30'd0, slot}, 32'd0);
        check("t1_ov_cnt", ov_cnt, 32'd1);

        // Idle gaps between beats
        push_frame(8'hA0, 8'hB1, 8'hC2, 8'hD3);
        beat(8'hA0, 1'b1, 2'd0, 1'b0, 1'b1); idle(2);
        beat(8'hB1, 1'b0, 2'd1, 1'b0, 1'b1); idle(2);
        beat(8'hC2, 1'b0, 2'd2, 1'b0, 1'b1); idle(2);
        beat(8'hD3, 1'b0, 2'd3, 1'b0, 1'b1); idle(2);
        check("t2_ov_cnt", ov_cnt, 32'd2);

        // Early SOF
        push_frame(8'h33, 8'h44, 8'h55, 8'h66);
        beat(8'h11, 1'b1, 2'd0, 1'b0, 1'b1);
        beat(8'h22, 1'b0, 2'd1, 1'b0, 1'b1);
        beat(8'h33, 1'b1, 2'd2, 1'b0, 1'b1);
        beat(8'h44, 1'b0, 2'd1, 1'b1, 1'b1);
        beat(8'h55, 1'b0, 2'd2, 1'b0, 1'b1);
        beat(8'h66, 1'b0, 2'd3, 1'b0, 1'b1);
        idle(2);
        check("t3_ov_cnt", ov_cnt, 32'd3);
        check("t3_err_cnt", err_cnt, 32'd1);

        // Missing SOF
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        beat(8'h01, 1'b1, 2'd0, 1'b0, 1'b1);
        beat(8'h02, 1'b0, 2'd1, 1'b0, 1'b1);
        beat(8'h03, 1'b0, 2'd2, 1'b0, 1'b1);
        beat(8'h04, 1'b0, 2'd3, 1'b0, 1'b1);
        beat(8'h05, 1'b0, 2'd0, 1'b0, 1'b1);
        beat(8'h06, 1'b1, 2'd0, 1'b1, 1'b0);
        check("t4_hold", {out0, out1, out2, out3}, 32'h01020304);
        push_frame(8'h06, 8'h07, 8'h08, 8'h09);
        beat(8'h07, 1'b0, 2'd1, 1'b0, 1'b1);
        beat(8'h08, 1'b0, 2'd2, 1'b0, 1'b1);
        beat(8'h09, 1'b0, 2'd3, 1'b0, 1'b1);
        idle(2);
        check("t4_ov_cnt", ov_cnt, 32'd5);
        check("t4_err_cnt", err_cnt, 32'd2);

        // Hunt discard after reset
        do_reset();
        push_frame(8'hF0, 8'hF1, 8'hF2, 8'hF3);
        beat(8'h7A, 1'b0, 2'd0, 1'b0, 1'b0);
        beat(8'h7B, 1'b0, 2'd0, 1'b0, 1'b0);
        beat(8'hF0, 1'b1, 2'd0, 1'b0, 1'b0);
        beat(8'hF1, 1'b0, 2'd1, 1'b0, 1'b1);
        beat(8'hF2, 1'b0, 2'd2, 1'b0, 1'b1);
        beat(8'hF3, 1'b0, 2'd3, 1'b0, 1'b1);
        idle(2);
        check("t5_ov_cnt", ov_cnt, 32'd6);
        check("t5_err_cnt", err_cnt, 32'd2);

        // Asynchronous reset mid-frame
        beat(8'hC0, 1'b1, 2'd0, 1'b0, 1'b1);
        beat(8'hC1, 1'b0, 2'd1, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_out", {out0, out1, out2, out3}, 32'd0);
        check("t6_locked", {31'd0, locked}, 32'd0);
        check("t6_slot", {30'd0, slot}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'hC2, 1'b0, 2'd0, 1'b0, 1'b0);
        beat(8'hC3, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(2);
        check("t6_ov_cnt", ov_cnt, 32'd6);
        check("t6_locked_end", {31'd0, locked}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
